// File: rtl/pattern_scan_ctrl.sv
// Pattern-window scan controller: captures a byte, slides a PAT_W window across it, reports a match vector.
// Optional build macro MATCH_COUNT_EN adds a match_cnt output counting matching windows.
module pattern_scan_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PAT_W = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  localparam int unsigned NWIN = DATA_W - PAT_W + 1,
  localparam int unsigned IDX_W = $clog2(NWIN),
  localparam int unsigned CNT_W = $clog2(NWIN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  win_idx,
`ifdef MATCH_COUNT_EN
  output logic [CNT_W-1:0]  match_cnt,
`endif
  output logic [DATA_W-1:0] result
);

  localparam int unsigned SEL_W = $clog2(DATA_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [DATA_W-1:0] captured, captured_nxt;
  logic [DATA_W-1:0] result_nxt;
  logic [IDX_W-1:0]  win_idx_nxt;
  logic              busy_nxt, done_nxt;
  logic [SEL_W-1:0]  win_msb;
  logic [PAT_W-1:0]  window;
  logic              hit;
`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0]  match_cnt_nxt;
`endif

  // Window k is MSB-aligned at k=0 and slides one bit toward the LSB per step.
  always_comb begin
    win_msb = SEL_W'(DATA_W - 1) - SEL_W'(win_idx);
    window  = captured[win_msb -: PAT_W];
    hit     = (window == PATTERN);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    captured_nxt = captured;
    result_nxt   = result;
    win_idx_nxt  = win_idx;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
`ifdef MATCH_COUNT_EN
    match_cnt_nxt = match_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          captured_nxt = a_in;
          result_nxt   = '0;
          win_idx_nxt  = '0;
          busy_nxt     = 1'b1;
          state_nxt    = S_SCAN;
`ifdef MATCH_COUNT_EN
          match_cnt_nxt = '0;
`endif
        end
      end
      S_SCAN: begin
        if (hit) begin
          result_nxt = result | (DATA_W'(1) << (IDX_W'(NWIN - 1) - win_idx));
`ifdef MATCH_COUNT_EN
          match_cnt_nxt = match_cnt + CNT_W'(1);
`endif
        end
        if (win_idx == IDX_W'(NWIN - 1)) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else begin
          win_idx_nxt = win_idx + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_nxt   = S_IDLE;
        busy_nxt    = 1'b0;
        win_idx_nxt = '0;
      end
      default: begin
        state_nxt   = S_IDLE;
        busy_nxt    = 1'b0;
        win_idx_nxt = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      captured <= '0;
      result   <= '0;
      win_idx  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      captured <= captured_nxt;
      result   <= result_nxt;
      win_idx  <= win_idx_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

`ifdef MATCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt <= '0;
    end else begin
      match_cnt <= match_cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: directed and random scans checked against a window-matching reference.
module tb_pattern_scan_ctrl;

  localparam int DATA_W = 8;
  localparam int PAT_W = 4;
  localparam int NWIN = DATA_W - PAT_W + 1;
  localparam int PAT_VAL = 10;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic       busy;
  logic       done;
  logic [2:0] win_idx;
  logic [7:0] result;
`ifdef MATCH_COUNT_EN
  logic [2:0] match_cnt;
`endif

  int checks;
  int failures;

  pattern_scan_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .busy    (busy),
    .done    (done),
    .win_idx (win_idx),
`ifdef MATCH_COUNT_EN
    .match_cnt (match_cnt),
`endif
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: slide a 4-bit window from the MSB end, window k hit sets bit NWIN-1-k.
  function automatic logic [7:0] ref_result(input logic [7:0] w);
    int wi;
    logic [7:0] r;
    wi = int'(w);
    r = 8'h00;
    for (int k = 0; k < NWIN; k++) begin
      if (((wi >> (DATA_W - PAT_W - k)) & 15) == PAT_VAL) r[NWIN - 1 - k] = 1'b1;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered on the first cycle after an accepted start; leaves on the first IDLE cycle after done.
  task automatic finish_scan(input logic [7:0] v, input bit poke);
    logic [7:0] exp;
    exp = ref_result(v);
    for (int k = 0; k < NWIN; k++) begin
      chk("scan_win_idx", 32'(win_idx), 32'(k));
      chk("scan_busy", 32'(busy), 32'd1);
      chk("scan_done", 32'(done), 32'd0);
      if (poke && k == 2) begin
        start = 1'b1;
        a_in  = 8'hFF;
      end else begin
        start = 1'b0;
        a_in  = 8'($urandom);
      end
      tick();
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_result", 32'(result), 32'(exp));
`ifdef MATCH_COUNT_EN
    chk("done_match_cnt", 32'(match_cnt), 32'($countones(exp)));
`endif
    if (poke) begin
      start = 1'b1;
      a_in  = 8'hFF;
    end
    tick();
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_win_idx", 32'(win_idx), 32'd0);
    chk("post_result_held", 32'(result), 32'(exp));
  endtask

  task automatic run_scan(input logic [7:0] v, input bit poke);
    start = 1'b1;
    a_in  = v;
    tick();
    finish_scan(v, poke);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = 8'h00;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_win_idx", 32'(win_idx), 32'd0);
`ifdef MATCH_COUNT_EN
    chk("rst_match_cnt", 32'(match_cnt), 32'd0);
`endif
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    run_scan(8'hA0, 1'b0);
    run_scan(8'hAA, 1'b0);
    run_scan(8'h0A, 1'b0);
    run_scan(8'h00, 1'b0);

    // Starts during SCAN and on the done cycle are ignored; the held start is then accepted.
    run_scan(8'hAA, 1'b1);
    tick();
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_result_clr", 32'(result), 32'd0);
    finish_scan(8'hFF, 1'b0);

    // Abort mid-scan at window 2.
    start = 1'b1;
    a_in  = 8'hAA;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("abort_win_idx", 32'(win_idx), 32'd2);
    chk("abort_partial", 32'(result), 32'h10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_win_idx0", 32'(win_idx), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
`ifdef MATCH_COUNT_EN
    chk("abort_match_cnt", 32'(match_cnt), 32'd0);
`endif
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end
    run_scan(8'hA0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_scan(8'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
